// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes, R-type functs,
// ALU operation codes and the one-hot instruction class produced by ctrl_decode.
package mc_ctrl_pkg;

    localparam logic [2:0] S_IF   = 3'b000;
    localparam logic [2:0] S_ID   = 3'b001;
    localparam logic [2:0] S_EXE  = 3'b010;
    localparam logic [2:0] S_MEM  = 3'b011;
    localparam logic [2:0] S_WB   = 3'b100;
    localparam logic [2:0] S_HALT = 3'b101;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef struct packed {
        logic rtype;
        logic itype;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic halt;
        logic nop;
    } iclass_t;

    // Returns {known, aluop}; unknown functs fall back to add and must not write back.
    function automatic logic [3:0] rtype_aluop(input logic [5:0] funct);
        case (funct)
            FN_ADD:  rtype_aluop = {1'b1, ALU_ADD};
            FN_SUB:  rtype_aluop = {1'b1, ALU_SUB};
            FN_AND:  rtype_aluop = {1'b1, ALU_AND};
            FN_OR:   rtype_aluop = {1'b1, ALU_OR};
            FN_SLT:  rtype_aluop = {1'b1, ALU_SLT};
            default: rtype_aluop = {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to one-hot instruction class; purely combinational.
// HALT_OP is checked first so it wins even if it aliases a real opcode.
module ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic [5:0] opcode,
    output iclass_t    cls
);

    always_comb begin
        cls = '0;
        if (opcode == HALT_OP) begin
            cls.halt = 1'b1;
        end else begin
            case (opcode)
                OP_RTYPE:        cls.rtype = 1'b1;
                OP_ADDI, OP_ORI: cls.itype = 1'b1;
                OP_LW:           cls.lw    = 1'b1;
                OP_SW:           cls.sw    = 1'b1;
                OP_BEQ:          cls.beq   = 1'b1;
                OP_J:            cls.j     = 1'b1;
                default:         cls.nop   = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style controller: registered IF/ID/EXE/MEM/WB/HALT state, Moore/Mealy
// control outputs decoded combinationally from state, opcode, funct and zero.
module multi_cycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       RegDst,
    output logic       RegWre,
    output logic       ALUSrcB,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR,
    output logic       ExtSel,
    output logic [2:0] ALUOp,
    output logic [2:0] state,
    output logic       halted
);

    iclass_t    cls;
    logic [2:0] state_q;
    logic [2:0] state_nxt;
    logic [3:0] rfn;
    logic       is_ori;
    logic       in_id, in_exe, in_mem, in_wb;
    logic       decoded;

    ctrl_decode #(.HALT_OP(HALT_OP)) u_decode (
        .opcode (opcode),
        .cls    (cls)
    );

    assign rfn    = rtype_aluop(funct);
    assign is_ori = cls.itype && (opcode == OP_ORI);

    always_comb begin
        state_nxt = S_IF;
        case (state_q)
            S_IF:   state_nxt = S_ID;
            S_ID: begin
                if (cls.halt)              state_nxt = S_HALT;
                else if (cls.j || cls.nop) state_nxt = S_IF;
                else                       state_nxt = S_EXE;
            end
            S_EXE: begin
                if (cls.beq)               state_nxt = S_IF;
                else if (cls.lw || cls.sw) state_nxt = S_MEM;
                else                       state_nxt = S_WB;
            end
            S_MEM:  state_nxt = cls.lw ? S_WB : S_IF;
            S_WB:   state_nxt = S_IF;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IF;
        endcase
    end

    // Async reset drops straight into IF, so every write strobe collapses the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_nxt;
    end

    assign in_id   = (state_q == S_ID);
    assign in_exe  = (state_q == S_EXE);
    assign in_mem  = (state_q == S_MEM);
    assign in_wb   = (state_q == S_WB);
    assign decoded = in_id || in_exe || in_mem || in_wb;

    always_comb begin
        PCWre     = (state_nxt == S_IF) && (state_q != S_HALT);
        IRWre     = (state_q == S_IF);
        PCSrc     = 2'b00;
        if (in_id && cls.j)              PCSrc = 2'b10;
        else if (in_exe && cls.beq && zero) PCSrc = 2'b01;
        RegWre    = in_wb && (cls.itype || cls.lw || (cls.rtype && rfn[3]));
        RegDst    = in_wb && cls.rtype;
        DBDataSrc = in_wb && cls.lw;
        mRD       = in_mem && cls.lw;
        mWR       = in_mem && cls.sw;
        ALUSrcB   = (in_exe || in_mem || in_wb) && (cls.itype || cls.lw || cls.sw);
        // IR contents are not meaningful in IF/HALT, so operand-related controls stay idle there.
        ExtSel    = decoded && !is_ori;
        ALUOp     = ALU_ADD;
        if (decoded) begin
            if (cls.rtype)    ALUOp = rfn[2:0];
            else if (cls.beq) ALUOp = ALU_SUB;
            else if (is_ori)  ALUOp = ALU_OR;
        end
        halted    = (state_q == S_HALT);
    end

    assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl against a step-indexed instruction model.
module tb_multi_cycle_ctrl;

    localparam int K_R = 0, K_ADDI = 1, K_ORI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_J = 6, K_NOP = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       PCWre, IRWre, RegDst, RegWre, ALUSrcB, DBDataSrc, mRD, mWR, ExtSel, halted;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp, state;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegDst(RegDst), .RegWre(RegWre),
        .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .ExtSel(ExtSel),
        .ALUOp(ALUOp), .state(state), .halted(halted)
    );

    function automatic logic [14:0] ctrl_now();
        return {PCWre, PCSrc, IRWre, RegDst, RegWre, ALUSrcB, DBDataSrc, mRD, mWR, ExtSel, ALUOp, halted};
    endfunction

    function automatic logic [5:0] kind_opcode(input int kind);
        case (kind)
            K_R:    return 6'b000000;
            K_ADDI: return 6'b001000;
            K_ORI:  return 6'b001101;
            K_LW:   return 6'b100011;
            K_SW:   return 6'b101011;
            K_BEQ:  return 6'b000100;
            K_J:    return 6'b000010;
            default: return 6'b010101;
        endcase
    endfunction

    function automatic int n_cycles(input int kind);
        case (kind)
            K_J, K_NOP: return 2;
            K_BEQ:      return 3;
            K_LW:       return 5;
            default:    return 4;
        endcase
    endfunction

    // Phase sequence: IF, ID, EXE, then MEM for memory ops, WB last for writers.
    function automatic logic [2:0] state_at(input int kind, input int k);
        case (k)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b010;
            3: return (kind == K_LW || kind == K_SW) ? 3'b011 : 3'b100;
            default: return 3'b100;
        endcase
    endfunction

    // {known, aluop} for an R-type funct field.
    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b1000;
            6'b100010: return 4'b1001;
            6'b100100: return 4'b1010;
            6'b100101: return 4'b1011;
            6'b101010: return 4'b1100;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic [14:0] exp_ctrl(input int kind, input logic [5:0] fn, input logic z, input int k);
        int n;
        logic last, writes, pcw, irw, rdst, rwe, asb, dbd, mrd_e, mwr_e, ext;
        logic [1:0] psrc;
        logic [2:0] aop;
        logic [3:0] ra;
        n      = n_cycles(kind);
        ra     = r_alu(fn);
        last   = (k == n - 1);
        writes = (kind == K_ADDI) || (kind == K_ORI) || (kind == K_LW) || (kind == K_R && ra[3]);
        pcw    = last;
        psrc   = (kind == K_J && k == 1) ? 2'b10 : (kind == K_BEQ && k == 2 && z) ? 2'b01 : 2'b00;
        irw    = (k == 0);
        rwe    = last && writes;
        rdst   = last && (kind == K_R);
        asb    = (k >= 2) && (kind == K_ADDI || kind == K_ORI || kind == K_LW || kind == K_SW);
        dbd    = (kind == K_LW) && (k == 4);
        mrd_e  = (kind == K_LW) && (k == 3);
        mwr_e  = (kind == K_SW) && (k == 3);
        ext    = (k >= 1) && (kind != K_ORI);
        if (k == 0)             aop = 3'b000;
        else if (kind == K_R)   aop = ra[2:0];
        else if (kind == K_BEQ) aop = 3'b001;
        else if (kind == K_ORI) aop = 3'b011;
        else                    aop = 3'b000;
        return {pcw, psrc, irw, rdst, rwe, asb, dbd, mrd_e, mwr_e, ext, aop, 1'b0};
    endfunction

    // Precondition: just after a rising edge with the FSM in IF.
    task automatic run_instr(input int kind, input logic [5:0] fn, input logic z,
                             input int abort_at, input string tag);
        int n;
        logic [14:0] exp;
        n      = n_cycles(kind);
        opcode = kind_opcode(kind);
        funct  = fn;
        zero   = z;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checks++;
            if (state !== state_at(kind, k)) begin
                fails++;
                $display("FAIL %s state step %0d: got %b want %b", tag, k, state, state_at(kind, k));
            end
            exp = exp_ctrl(kind, fn, z, k);
            checks++;
            if (ctrl_now() !== exp) begin
                fails++;
                $display("FAIL %s ctrl step %0d: got %b want %b", tag, k, ctrl_now(), exp);
            end
            checks++;
            if ((mRD & mWR) !== 1'b0) begin
                fails++;
                $display("FAIL %s mrd_mwr_excl step %0d: got %b want 0", tag, k, mRD & mWR);
            end
            if (k == abort_at) begin
                #2 reset = 1'b1;
                #1;
                checks++;
                if ({state, mWR, IRWre} !== {3'b000, 1'b0, 1'b1}) begin
                    fails++;
                    $display("FAIL %s async_abort: got state=%b mWR=%b IRWre=%b want 000 0 1",
                             tag, state, mWR, IRWre);
                end
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    checks++;
                    if (ctrl_now() !== 15'h0800 || state !== 3'b000) begin
                        fails++;
                        $display("FAIL %s in_reset cycle %0d: got %b/%b want %b/000",
                                 tag, c, ctrl_now(), state, 15'h0800);
                    end
                end
                @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        opcode = 6'b100011;
        funct  = 6'($urandom);
        zero   = 1'b1;
        #3;
        checks++;
        if ({state, ctrl_now()} !== {3'b000, 15'h0800}) begin
            fails++;
            $display("FAIL reset_early: got %b/%b want 000/%b", state, ctrl_now(), 15'h0800);
        end
        @(negedge clk);
        opcode = 6'b111111;
        #1;
        checks++;
        if ({state, ctrl_now()} !== {3'b000, 15'h0800}) begin
            fails++;
            $display("FAIL reset_held: got %b/%b want 000/%b", state, ctrl_now(), 15'h0800);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_rtype();
        logic [5:0] fns [6];
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        foreach (fns[i]) run_instr(K_R, fns[i], 1'($urandom), -1, "rtype");
        run_instr(K_ADDI, 6'($urandom), 1'b0, -1, "addi");
        run_instr(K_ORI, 6'($urandom), 1'b0, -1, "ori");
    endtask

    task automatic test_lw_sw();
        run_instr(K_LW, 6'($urandom), 1'b0, -1, "lw");
        run_instr(K_SW, 6'($urandom), 1'b1, -1, "sw");
    endtask

    task automatic test_branch_jump();
        run_instr(K_BEQ, 6'($urandom), 1'b1, -1, "beq_taken");
        run_instr(K_BEQ, 6'($urandom), 1'b0, -1, "beq_not_taken");
        run_instr(K_J, 6'($urandom), 1'b1, -1, "j");
        run_instr(K_NOP, 6'($urandom), 1'b0, -1, "nop");
    endtask

    task automatic test_reset_mid_sw();
        run_instr(K_SW, 6'($urandom), 1'b0, 3, "sw_abort");
        run_instr(K_R, 6'b100000, 1'b0, -1, "after_abort");
    endtask

    task automatic test_back_to_back();
        int kind;
        logic [5:0] fn;
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 7));
            fn   = 6'($urandom);
            if (kind == K_R && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 4))
                    0: fn = 6'b100000;
                    1: fn = 6'b100010;
                    2: fn = 6'b100100;
                    3: fn = 6'b100101;
                    default: fn = 6'b101010;
                endcase
            end
            run_instr(kind, fn, 1'($urandom), -1, "random");
        end
    endtask

    task automatic test_halt();
        opcode = 6'b111111;
        funct  = 6'($urandom);
        @(negedge clk);
        checks++;
        if (state !== 3'b000) begin
            fails++;
            $display("FAIL halt_if: got %b want 000", state);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({state, PCWre} !== {3'b001, 1'b0}) begin
            fails++;
            $display("FAIL halt_id: got %b/%b want 001/0", state, PCWre);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1 opcode = 6'($urandom);
            zero = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({state, ctrl_now()} !== {3'b101, 15'h0001}) begin
                fails++;
                $display("FAIL halt_hold cycle %0d: got %b/%b want 101/%b", c, state, ctrl_now(), 15'h0001);
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({state, halted} !== {3'b000, 1'b0}) begin
            fails++;
            $display("FAIL halt_reset: got %b/%b want 000/0", state, halted);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        run_instr(K_LW, 6'($urandom), 1'b0, -1, "after_halt");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_sw();
        test_branch_jump();
        test_reset_mid_sw();
        test_back_to_back();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
